// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode FND scanner with frame snapshot, switch blanking and blink (iClk, iRst, iTick1kHz, iFndData, iBlinkMask, iDotMask -> oDigitSel, oSeg, oDp)
module fnd_scan_ctrl #(
  parameter int P_BLINK_HALF_MS = 500,
  parameter int P_BLANK_CYCLES  = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iTick1kHz,
  input  logic [15:0] iFndData,
  input  logic [3:0]  iBlinkMask,
  input  logic [3:0]  iDotMask,
  output logic [3:0]  oDigitSel,
  output logic [6:0]  oSeg,
  output logic        oDp
);
  localparam logic [111:0] GLYPHS = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                     7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [1:0]  idx, idxNxt;
  logic [7:0]  blankCnt, blankNxt;
  logic [9:0]  blinkCnt, blinkNxt;
  logic        blinkPhase, phaseNxt, blinkWrap, snap, dark;
  logic [15:0] snapData, dataNxt;
  logic [3:0]  snapBlink, maskNxt, snapDot, dotNxt, nib;
  logic [6:0]  glyph;
  always_comb begin
    idxNxt    = iTick1kHz ? idx + 2'd1 : idx;
    blankNxt  = iTick1kHz ? 8'(P_BLANK_CYCLES) : blankCnt - 8'(blankCnt != 8'd0);
    blinkWrap = iTick1kHz && blinkCnt == 10'(P_BLINK_HALF_MS - 1);
    blinkNxt  = iTick1kHz ? (blinkWrap ? 10'd0 : blinkCnt + 10'd1) : blinkCnt;
    phaseNxt  = blinkPhase ^ blinkWrap;
    snap      = iTick1kHz && idx == 2'd3;
    dataNxt   = snap ? iFndData : snapData;
    maskNxt   = snap ? iBlinkMask : snapBlink;
    dotNxt    = snap ? iDotMask : snapDot;
    nib       = dataNxt[4*idxNxt +: 4];
    glyph     = GLYPHS[7*nib +: 7];
    dark      = blankNxt != 8'd0 || (phaseNxt && maskNxt[idxNxt]);
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      idx        <= 2'd0;
      blankCnt   <= 8'(P_BLANK_CYCLES);
      blinkCnt   <= 10'd0;
      blinkPhase <= 1'b0;
      snapData   <= 16'h0;
      snapBlink  <= 4'h0;
      snapDot    <= 4'h0;
      oDigitSel  <= 4'hF;
      oSeg       <= 7'h7F;
      oDp        <= 1'b1;
    end else begin
      idx        <= idxNxt;
      blankCnt   <= blankNxt;
      blinkCnt   <= blinkNxt;
      blinkPhase <= phaseNxt;
      snapData   <= dataNxt;
      snapBlink  <= maskNxt;
      snapDot    <= dotNxt;
      oDigitSel  <= dark ? 4'hF : ~(4'b0001 << idxNxt);
      oSeg       <= dark ? 7'h7F : glyph;
      oDp        <= dark | ~dotNxt[idxNxt];
    end
  end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed self-checking bench for fnd_scan_ctrl (default, blink/blank-3 and blank-0 instances)
module tb_fnd_scan_ctrl;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iTick1kHz = 1'b0;
  logic [15:0] iFndData = 16'h0;
  logic [3:0]  iBlinkMask = 4'h0;
  logic [3:0]  iDotMask = 4'h0;
  logic [3:0]  selA, selB, selC;
  logic [6:0]  segA, segB, segC;
  logic        dpA, dpB, dpC;
  int tests = 0;
  int fails = 0;
  int offB, offC, offA;
  logic [3:0] blinkExp [13] = '{4'hD, 4'hB, 4'h7, 4'hF, 4'hF, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hF};

  always #5 iClk = ~iClk;

  fnd_scan_ctrl dutA (.iClk(iClk), .iRst(iRst), .iTick1kHz(iTick1kHz), .iFndData(iFndData),
    .iBlinkMask(iBlinkMask), .iDotMask(iDotMask), .oDigitSel(selA), .oSeg(segA), .oDp(dpA));
  fnd_scan_ctrl #(.P_BLINK_HALF_MS(4), .P_BLANK_CYCLES(3)) dutB (.iClk(iClk), .iRst(iRst),
    .iTick1kHz(iTick1kHz), .iFndData(iFndData), .iBlinkMask(iBlinkMask), .iDotMask(iDotMask),
    .oDigitSel(selB), .oSeg(segB), .oDp(dpB));
  fnd_scan_ctrl #(.P_BLANK_CYCLES(0)) dutC (.iClk(iClk), .iRst(iRst), .iTick1kHz(iTick1kHz),
    .iFndData(iFndData), .iBlinkMask(iBlinkMask), .iDotMask(iDotMask),
    .oDigitSel(selC), .oSeg(segC), .oDp(dpC));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    iTick1kHz = 1'b1;
    @(negedge iClk);
    iTick1kHz = 1'b0;
  endtask

  task automatic advance();
    tick();
    repeat (4) @(negedge iClk);
  endtask

  task automatic countOff();
    offA = 0; offB = 0; offC = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge iClk);
      offA += int'(selA == 4'hF);
      offB += int'(selB == 4'hF);
      offC += int'(selC == 4'hF);
    end
  endtask

  initial begin
    repeat (3) @(negedge iClk);
    chk("rst_sel", {12'h0, selA}, 16'hF);
    chk("rst_seg", {9'h0, segA}, 16'h7F);
    chk("rst_dp", {15'h0, dpA}, 16'h1);
    chk("rst_sel_c", {12'h0, selC}, 16'hF);
    iRst = 1'b0;
    @(negedge iClk);
    chk("rel_c_sel", {12'h0, selC}, 16'hE);
    repeat (2) @(negedge iClk);
    chk("rel_blank3", {12'h0, selA}, 16'hF);
    chk("rel_b_sel", {12'h0, selB}, 16'hE);
    @(negedge iClk);
    chk("rel_sel", {12'h0, selA}, 16'hE);
    chk("rel_seg", {9'h0, segA}, 16'h40);
    chk("rel_dp", {15'h0, dpA}, 16'h1);

    iFndData = 16'h12AF;
    repeat (4) advance();
    chk("scan0_sel", {12'h0, selA}, 16'hE);
    chk("scan0_seg", {9'h0, segA}, 16'h0E);
    advance();
    chk("scan1_sel", {12'h0, selA}, 16'hD);
    chk("scan1_seg", {9'h0, segA}, 16'h08);
    advance();
    chk("scan2_sel", {12'h0, selA}, 16'hB);
    chk("scan2_seg", {9'h0, segA}, 16'h24);
    advance();
    chk("scan3_sel", {12'h0, selA}, 16'h7);
    chk("scan3_seg", {9'h0, segA}, 16'h79);

    iFndData = 16'h1111;
    advance();
    advance();
    iFndData = 16'h2222;
    advance();
    chk("coh_d2", {9'h0, segA}, 16'h79);
    advance();
    chk("coh_d3", {9'h0, segA}, 16'h79);
    advance();
    chk("coh_next_d0", {9'h0, segA}, 16'h24);

    iDotMask = 4'b0100;
    repeat (4) advance();
    chk("dot_d0", {15'h0, dpA}, 16'h1);
    advance();
    chk("dot_d1", {15'h0, dpA}, 16'h1);
    tick();
    chk("dot_blank_sel", {12'h0, selA}, 16'hF);
    chk("dot_blank_dp", {15'h0, dpA}, 16'h1);
    repeat (4) @(negedge iClk);
    chk("dot_d2_sel", {12'h0, selA}, 16'hB);
    chk("dot_d2_dp", {15'h0, dpA}, 16'h0);
    advance();
    chk("dot_d3", {15'h0, dpA}, 16'h1);

    iRst = 1'b1;
    iTick1kHz = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    iTick1kHz = 1'b0;
    chk("rst_tick_sel", {12'h0, selA}, 16'hF);
    iBlinkMask = 4'b0011;
    iDotMask = 4'b0000;
    for (int t = 0; t < 13; t++) begin
      advance();
      chk($sformatf("blink_t%0d", t + 1), {12'h0, selB}, {12'h0, blinkExp[t]});
    end
    chk("blink_dark_seg", {9'h0, segB}, 16'h7F);
    chk("blink_slow_lit", {12'h0, selA}, 16'hD);

    countOff();
    chk("blank_b3", offB[15:0], 16'd3);
    chk("blank_c0", offC[15:0], 16'd0);
    chk("blank_a4", offA[15:0], 16'd4);
    tick();
    @(negedge iClk);
    countOff();
    chk("retick_b3", offB[15:0], 16'd3);
    chk("retick_c0", offC[15:0], 16'd0);
    chk("retick_sel", {12'h0, selB}, 16'hE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
